// File: rtl/muon_decay_timer_if.sv
// Detector-line pulse in, BCD display words and status out.
// The producer side (bench/front end) drives pulse_in; the timer drives everything else.
interface muon_decay_timer_if;
    logic        pulse_in;
    logic [15:0] digits_lifetime;
    logic [15:0] digits_events;
    logic [15:0] digits_timeouts;
    logic        busy;
    logic        capture_strobe;

    modport master (
        output pulse_in,
        input  digits_lifetime, digits_events, digits_timeouts, busy, capture_strobe
    );

    modport slave (
        input  pulse_in,
        output digits_lifetime, digits_events, digits_timeouts, busy, capture_strobe
    );
endinterface

// File: rtl/muon_decay_timer.sv
// Times muon start->decay pulses in prescaled ticks and publishes BCD lifetime/event/timeout words.
// Latency: a pulse edge is acted on 3 clk edges after it rises; all outputs are registered.
// Backpressure: none, the pulse input is free-running and the outputs are level words.
module muon_decay_timer #(
    parameter int TICK_DIV      = 10,
    parameter int WINDOW_TICKS  = 200,
    parameter int MIN_GAP_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    muon_decay_timer_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    localparam logic [15:0] WINDOW_BCD  = to_bcd(WINDOW_TICKS);
    localparam logic [15:0] MIN_GAP_BCD = to_bcd(MIN_GAP_TICKS);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        bcd_inc = r;
    endfunction

    function automatic logic [15:0] bcd_sat_inc(input logic [15:0] v);
        bcd_sat_inc = (v == 16'h9999) ? v : bcd_inc(v);
    endfunction

    typedef enum logic {IDLE, TIMING} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   tcount_q, tcount_d;
    logic [15:0]   life_q, life_d;
    logic [15:0]   events_q, events_d;
    logic [15:0]   timeouts_q, timeouts_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          s1, s2, s3;
    logic          pulse_edge;

    // s1 is the metastability catcher; edges are taken from the settled s2/s3 pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse_edge = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tcount_q   <= '0;
            life_q     <= '0;
            events_q   <= '0;
            timeouts_q <= '0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tcount_q   <= tcount_d;
            life_q     <= life_d;
            events_q   <= events_d;
            timeouts_q <= timeouts_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tcount_d   = tcount_q;
        life_d     = life_q;
        events_d   = events_q;
        timeouts_d = timeouts_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pulse_edge) begin
                    state_d  = TIMING;
                    presc_d  = '0;
                    tcount_d = '0;
                    busy_d   = 1'b1;
                end
            end
            TIMING: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    tcount_d = bcd_inc(tcount_q);
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // A valid stop takes priority over a timeout landing in the same cycle
                if (pulse_edge && (tcount_q >= MIN_GAP_BCD)) begin
                    life_d   = tcount_q;
                    events_d = bcd_sat_inc(events_q);
                    strobe_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (tcount_q == WINDOW_BCD) begin
                    timeouts_d = bcd_sat_inc(timeouts_q);
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.digits_lifetime = life_q;
    assign bus.digits_events   = events_q;
    assign bus.digits_timeouts = timeouts_q;
    assign bus.busy            = busy_q;
    assign bus.capture_strobe  = strobe_q;

endmodule
